// File: rtl/modo_sequencer_pkg.sv
// Shared definitions for the MODO command sequencer: sizes, MODO mode codes,
// FSM state encoding and the packed command word.
package modo_sequencer_pkg;

  localparam int DEPTH = 4;
  localparam int W     = 4;
  localparam int LEN_W = 4;

  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DOWN = 2'b01;
  localparam logic [1:0] MODO_UP3  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0]       modo;
    logic [W-1:0]     d;
    logic [LEN_W-1:0] len;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic drives_counter(state_t s);
    return (s == S_LOAD) || (s == S_RUN);
  endfunction

endpackage

// File: rtl/modo_sequencer_if.sv
// Bundle between the sequencer, its host (command side) and the MODO counter.
interface modo_sequencer_if;
  import modo_sequencer_pkg::*;

  // Command handshake: a command is transferred on a rising clk edge where
  // cmd_valid and cmd_ready are both high; the payload must be stable while
  // cmd_valid is high, and cmd_ready never depends on cmd_valid.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_modo;
  logic [W-1:0]     cmd_d;
  logic [LEN_W-1:0] cmd_len;
  logic             pause;

  logic [W-1:0]     q;
  logic             rco;
  logic             enable;
  logic [1:0]       modo;
  logic [W-1:0]     d;

  logic             busy;
  logic             done;
  logic [W-1:0]     last_q;
  state_t           state;

  modport master (
    output cmd_valid, cmd_modo, cmd_d, cmd_len, pause, q, rco,
    input  cmd_ready, enable, modo, d, busy, done, last_q, state
  );

  modport slave (
    input  cmd_valid, cmd_modo, cmd_d, cmd_len, pause, q, rco,
    output cmd_ready, enable, modo, d, busy, done, last_q, state
  );

endinterface

// File: rtl/modo_cmd_fifo.sv
// Command FIFO: synchronous write, head word always visible on rdata_o,
// pointer-MSB full/empty detection.
module modo_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/modo_sequencer.sv
// Pops queued commands and drives the MODO counter pins through a
// preload cycle followed by a counted or rco-terminated run.
module modo_sequencer
  import modo_sequencer_pkg::*;
(
  input logic             clk,
  input logic             rst,
  modo_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  cmd_t             work_q, work_d;
  cmd_t             head;
  logic [CMD_W-1:0] head_raw;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             enable_q, enable_d;
  logic [1:0]       modo_q, modo_d;
  logic [W-1:0]     d_q, d_d;
  logic             done_q, done_d;
  logic [W-1:0]     last_q_q, last_q_d;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  assign push = bus.cmd_valid && !full;
  assign head = cmd_t'(head_raw);

  modo_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({bus.cmd_modo, bus.cmd_d, bus.cmd_len}),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    last_q_d = last_q_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !bus.pause) begin
          pop     = 1'b1;
          work_d  = head;
          rem_d   = head.len;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!bus.pause) state_d = (work_q.modo == MODO_LOAD) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        // Only enabled (unpaused) cycles advance the run.
        if (!bus.pause) begin
          if (work_q.len == '0) begin
            if (bus.rco) state_d = S_DONE;
          end else if (rem_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end
      end
      S_DONE: begin
        last_q_d = bus.q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    enable_d = drives_counter(state_d);
    modo_d   = (state_d == S_LOAD) ? MODO_LOAD :
               (state_d == S_RUN)  ? work_d.modo : MODO_UP;
    d_d      = work_d.d;
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      enable_q <= 1'b0;
      modo_q   <= MODO_UP;
      d_q      <= '0;
      done_q   <= 1'b0;
      last_q_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      enable_q <= enable_d;
      modo_q   <= modo_d;
      d_q      <= d_d;
      done_q   <= done_d;
      last_q_q <= last_q_d;
    end
  end

  assign bus.cmd_ready = !full;
  assign bus.enable    = enable_q && !bus.pause;
  assign bus.modo      = modo_q;
  assign bus.d         = d_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.last_q    = last_q_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_modo_sequencer.sv
// Directed bench for modo_sequencer with a behavioural MODO counter attached.
module tb_modo_sequencer;
  import modo_sequencer_pkg::*;

  logic clk;
  logic rst;

  modo_sequencer_if bus ();

  modo_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // MODO counter: 00 up, 01 down, 10 up-by-3, 11 load; rco flags the count
  // that lands on the terminal value (F up, 0 down).
  logic [W-1:0] cnt_q;
  always @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (bus.enable) begin
      case (bus.modo)
        MODO_LOAD: cnt_q <= bus.d;
        MODO_DOWN: cnt_q <= cnt_q - 4'd1;
        MODO_UP3:  cnt_q <= cnt_q + 4'd3;
        default:   cnt_q <= cnt_q + 4'd1;
      endcase
    end
  end
  assign bus.q   = cnt_q;
  assign bus.rco = bus.enable && ((bus.modo == MODO_UP   && cnt_q == 4'hE) ||
                                  (bus.modo == MODO_DOWN && cnt_q == 4'h1));

  // monitor + scoreboard capture
  int           en_cnt  = 0;
  int           run_cnt = 0;
  int           n_done  = 0;
  logic         sb_pending = 1'b0;
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.enable) en_cnt++;
    if (bus.enable && bus.modo != MODO_LOAD) run_cnt++;
    if (sb_pending) got_q.push_back(bus.last_q);
    sb_pending = bus.done;
    if (bus.done) n_done++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] m, input logic [W-1:0] dv, input logic [LEN_W-1:0] l);
    int k = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_modo  = m;
    bus.cmd_d     = dv;
    bus.cmd_len   = l;
    while (!bus.cmd_ready && k < 50) begin
      tick();
      k++;
    end
    check("push_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_load(input logic [W-1:0] exp_d, input string tag);
    int k = 0;
    while (!(bus.enable && bus.modo == MODO_LOAD) && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_modo"}, 32'(bus.modo), 32'(MODO_LOAD));
    check({tag, "_d"}, 32'(bus.d), 32'(exp_d));
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (n_done < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(n_done), 32'(target));
    tick();
    tick();
  endtask

  task automatic score(input string tag);
    check({tag, "_sb_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_sb_last_q"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  int en0;
  int run0;
  int nd0;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_modo  = '0;
    bus.cmd_d     = '0;
    bus.cmd_len   = '0;
    bus.pause     = 1'b0;
    rst = 1'b1;
    tick();
    tick();

    check("rst_enable", 32'(bus.enable), 32'd0);
    check("rst_modo", 32'(bus.modo), 32'd0);
    check("rst_d", 32'(bus.d), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_last_q", 32'(bus.last_q), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    rst = 1'b0;
    tick();

    // reset three cycles into a long run
    push(MODO_DOWN, 4'h3, 4'd8);
    tick();
    tick();
    tick();
    check("mid_state_run", 32'(bus.state), 32'(S_RUN));
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_enable", 32'(bus.enable), 32'd0);
    check("mid_rst_d", 32'(bus.d), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("mid_no_done", 32'(n_done), 32'd0);
    check("mid_idle", 32'(bus.state), 32'(S_IDLE));
    score("mid");

    // down-count from A for 3 cycles
    en0 = en_cnt; run0 = run_cnt; nd0 = n_done;
    exp_q.push_back(4'h7);
    push(MODO_DOWN, 4'hA, 4'd3);
    wait_load(4'hA, "t2_load");
    wait_done(nd0 + 1, 40, "t2_done");
    check("t2_enabled_cycles", 32'(en_cnt - en0), 32'd4);
    check("t2_run_cycles", 32'(run_cnt - run0), 32'd3);
    check("t2_last_q", 32'(bus.last_q), 32'h7);
    score("t2");

    // open-ended up-count from C until rco
    en0 = en_cnt; run0 = run_cnt; nd0 = n_done;
    exp_q.push_back(4'hF);
    push(MODO_UP, 4'hC, 4'd0);
    wait_load(4'hC, "t3_load");
    wait_done(nd0 + 1, 40, "t3_done");
    check("t3_enabled_cycles", 32'(en_cnt - en0), 32'd4);
    check("t3_last_q", 32'(bus.last_q), 32'hF);
    score("t3");

    // fill the FIFO while paused, fifth command waits for the first pop
    nd0 = n_done;
    bus.pause = 1'b1;
    push(MODO_UP, 4'h1, 4'd1);
    push(MODO_UP, 4'h3, 4'd1);
    push(MODO_UP, 4'h5, 4'd1);
    push(MODO_UP, 4'h7, 4'd1);
    exp_q.push_back(4'h2);
    exp_q.push_back(4'h4);
    exp_q.push_back(4'h6);
    exp_q.push_back(4'h8);
    exp_q.push_back(4'hA);
    check("t4_full_ready", 32'(bus.cmd_ready), 32'd0);
    check("t4_paused_idle", 32'(bus.busy), 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_modo  = MODO_UP;
    bus.cmd_d     = 4'h9;
    bus.cmd_len   = 4'd1;
    tick();
    check("t4_fifth_blocked", 32'(bus.cmd_ready), 32'd0);
    bus.pause = 1'b0;
    push(MODO_UP, 4'h9, 4'd1);
    wait_done(nd0 + 5, 120, "t4_five_done");
    score("t4");

    // two paused cycles inside a 4-cycle down run
    en0 = en_cnt; run0 = run_cnt; nd0 = n_done;
    exp_q.push_back(4'hB);
    push(MODO_DOWN, 4'hF, 4'd4);
    begin
      int k = 0;
      while (!(bus.enable && bus.modo == MODO_DOWN) && k < 20) begin
        tick();
        k++;
      end
    end
    check("t5_in_run", 32'(bus.state), 32'(S_RUN));
    bus.pause = 1'b1;
    #1;
    check("t5_pause_enable0", 32'(bus.enable), 32'd0);
    tick();
    check("t5_pause_enable1", 32'(bus.enable), 32'd0);
    check("t5_pause_hold", 32'(bus.state), 32'(S_RUN));
    tick();
    bus.pause = 1'b0;
    wait_done(nd0 + 1, 40, "t5_done");
    check("t5_enabled_cycles", 32'(en_cnt - en0), 32'd5);
    check("t5_run_cycles", 32'(run_cnt - run0), 32'd4);
    check("t5_last_q", 32'(bus.last_q), 32'hB);
    score("t5");

    // load-only command
    en0 = en_cnt; run0 = run_cnt; nd0 = n_done;
    exp_q.push_back(4'h5);
    push(MODO_LOAD, 4'h5, 4'd0);
    wait_load(4'h5, "t6_load");
    wait_done(nd0 + 1, 20, "t6_done");
    check("t6_enabled_cycles", 32'(en_cnt - en0), 32'd1);
    check("t6_run_cycles", 32'(run_cnt - run0), 32'd0);
    check("t6_last_q", 32'(bus.last_q), 32'h5);
    check("t6_idle_busy", 32'(bus.busy), 32'd0);
    score("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
